// File: rtl/pwm_pkg.sv
// Shared PWM constants and the capture FSM state type.
// The servo pulse limits are common to the servo generator and the capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    localparam int unsigned CLK_HZ        = 125_000_000;
    // 1 ms and 2 ms servo pulse widths at CLK_HZ
    localparam int unsigned SERVO_MIN_CYC = CLK_HZ / 1000;
    localparam int unsigned SERVO_MAX_CYC = CLK_HZ / 500;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for an asynchronous PWM input, plus a delay stage
// that turns the synchronised level into single-cycle rise/fall pulses.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_dly;
    assign fall  = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM input in clk cycles,
// publishing one measurement per period and flagging loss of signal on timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned TIMEOUT_CYC = (CLK_HZ / 1000) * 30,
    parameter int unsigned MIN_HIGH    = SERVO_MIN_CYC,
    parameter int unsigned MAX_HIGH    = SERVO_MAX_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             in_range,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LP_TIMEOUT_M1 = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LP_MIN_HIGH   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] LP_MAX_HIGH   = CNT_W'(MAX_HIGH);

    logic w_level_unused;
    logic w_rise;
    logic w_fall;

    cap_state_t       r_state;
    cap_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_high_lat;
    logic [CNT_W-1:0] w_high_lat_nxt;
    logic [CNT_W-1:0] r_high_count;
    logic [CNT_W-1:0] w_high_count_nxt;
    logic [CNT_W-1:0] r_period_count;
    logic [CNT_W-1:0] w_period_count_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_in_range;
    logic             w_in_range_nxt;
    logic             r_no_signal;
    logic             w_no_signal_nxt;
    logic             w_sat;
    logic             w_timeout;

    // Level output is kept on the sync block for duty monitors; unused here.
    pwm_edge_sync u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pwm_in),
        .level    (w_level_unused),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // Counter reaches TIMEOUT_CYC on this edge unless a rise reloads it.
    assign w_sat = (r_cnt >= LP_TIMEOUT_M1);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_rise) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt != LP_TIMEOUT) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_high_lat_nxt     = r_high_lat;
        w_high_count_nxt   = r_high_count;
        w_period_count_nxt = r_period_count;
        w_in_range_nxt     = r_in_range;
        w_valid_nxt        = 1'b0;
        w_no_signal_nxt    = r_no_signal;
        w_timeout          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                // A fall coinciding with saturation is too late to count.
                if (w_sat) begin
                    w_timeout = 1'b1;
                end else if (w_fall) begin
                    w_state_nxt    = LOW;
                    w_high_lat_nxt = r_cnt;
                end
            end
            LOW: begin
                // Rise wins over saturation so a period of TIMEOUT_CYC-1 still publishes.
                if (w_rise) begin
                    w_state_nxt        = HIGH;
                    w_period_count_nxt = r_cnt;
                    w_high_count_nxt   = r_high_lat;
                    w_in_range_nxt     = (r_high_lat >= LP_MIN_HIGH) &&
                                         (r_high_lat <= LP_MAX_HIGH);
                    w_valid_nxt        = 1'b1;
                    w_no_signal_nxt    = 1'b0;
                end else if (w_sat) begin
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_timeout) begin
            w_state_nxt        = IDLE;
            w_high_count_nxt   = '0;
            w_period_count_nxt = '0;
            w_in_range_nxt     = 1'b0;
            w_no_signal_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_high_lat     <= '0;
            r_high_count   <= '0;
            r_period_count <= '0;
            r_valid        <= 1'b0;
            r_in_range     <= 1'b0;
            r_no_signal    <= 1'b1;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_high_lat     <= w_high_lat_nxt;
            r_high_count   <= w_high_count_nxt;
            r_period_count <= w_period_count_nxt;
            r_valid        <= w_valid_nxt;
            r_in_range     <= w_in_range_nxt;
            r_no_signal    <= w_no_signal_nxt;
        end
    end

    assign high_count   = r_high_count;
    assign period_count = r_period_count;
    assign valid        = r_valid;
    assign in_range     = r_in_range;
    assign no_signal    = r_no_signal;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform (e.g. the `servo` or an `rgb` channel driven by `pwm_top`) and reports its high time and period in `clk` cycles. It is the receive-side counterpart to the PWM generators: it synchronises the asynchronous input, tracks edges with a small state machine, and publishes one measurement per complete period. A loss-of-signal timeout covers stuck-high and stuck-low inputs. It sits in the loopback/self-test path and in the lock's servo-monitor path.

## Interface

Parameters:

- `CNT_W`, 24, width of the cycle counter and of the count outputs.
- `TIMEOUT_CYC`, 3_750_000, cycles without a qualifying edge before signal loss is declared (30 ms at 125 MHz).
- `MIN_HIGH`, 125_000, lower bound of the in-range high time (1 ms).
- `MAX_HIGH`, 250_000, upper bound of the in-range high time (2 ms).

Ports:

- `clk`  in  1  system clock, 125 MHz.
- `reset`  in  1  synchronous, active-low reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `high_count`  out  `CNT_W`  last measured high time, in cycles.
- `period_count`  out  `CNT_W`  last measured rise-to-rise period, in cycles.
- `valid`  out  1  one-cycle strobe when new counts are published.
- `in_range`  out  1  registered result of `MIN_HIGH <= high_count <= MAX_HIGH`.
- `no_signal`  out  1  level; high from reset or timeout until the next valid measurement.

## Operation

- Input conditioning: `pwm_in` passes through a 2-FF synchroniser to give `s`. A third register holds `s_d`.
  - rise = `s & ~s_d`
  - fall = `~s & s_d`
- Counter `cnt`:
  - loads 1 on rise, otherwise increments;
  - saturates at `TIMEOUT_CYC`.
- States: IDLE, HIGH, LOW.
  - IDLE: rise → HIGH. Fall is ignored. No output is published, because the first rise never produces `valid`.
  - HIGH: fall → LOW and `high_lat <= cnt`. If `cnt == TIMEOUT_CYC` → IDLE with timeout.
  - LOW: rise → HIGH. On this transition:
    - `period_count <= cnt`
    - `high_count <= high_lat`
    - `in_range` is updated from `high_lat`
    - `valid <= 1`
    - `no_signal <= 0`
  - LOW: if `cnt == TIMEOUT_CYC` → IDLE with timeout.
- Timeout action, in the same cycle as the transition to IDLE:
  - `high_count`, `period_count` and `in_range` are cleared to 0;
  - `no_signal` is set to 1;
  - `valid` stays 0.
- Width rules:
  - All counts are unsigned `CNT_W` bits.
  - `TIMEOUT_CYC` must be less than `2**CNT_W`.
  - A period of `TIMEOUT_CYC` or more is reported only as a timeout, never as counts.
- Glitches: a single-cycle high or low on `s` is measured as-is (high time 1, or period 1 + prior high). There is no filtering.
- 100 % duty and 0 % duty both end in timeout from HIGH and from LOW respectively.

## Timing

- Reset values (while `reset == 0` at a clock edge):
  - state IDLE;
  - `cnt`, `high_lat`, synchroniser and `s_d` all 0;
  - `high_count`, `period_count`, `valid`, `in_range` all 0;
  - `no_signal` 1.
- Reset asserted mid-measurement discards all partial counts. The first rise after reset is again non-publishing.
- Latency: a rising edge of `pwm_in` first sampled at clock edge k produces `valid` high during the cycle after edge k+2. `valid` is exactly one cycle wide.
- `high_count`, `period_count` and `in_range` change only in the cycle `valid` rises, or on timeout/reset. They are stable between those events.
- Measured values equal the synchronised widths exactly. Constant input delay cancels, so there is no ±1 bias.
- Timeout fires on the edge where `cnt` reaches `TIMEOUT_CYC`, i.e. `TIMEOUT_CYC` cycles after the last rise.
  - Exception: in HIGH a late fall cannot rescue the measurement. The timeout is still measured from the rise.
- Simultaneous events: a rise and the saturation of `cnt` in the same cycle gives the rise priority (a measurement is published, no timeout).

## Structure

- Package `pwm_pkg` holds:
  - typedef enum `cap_state_t {IDLE, HIGH, LOW}`;
  - constant `CLK_HZ = 125_000_000`;
  - servo pulse constants `SERVO_MIN_CYC` and `SERVO_MAX_CYC`, shared with `pwm_servo`.
- One sub-module, `pwm_edge_sync`: 2-FF synchroniser plus `s_d`, with outputs `level`, `rise` and `fall`.
- `pwm_capture` holds the FSM, the counter and the output registers.

## Test plan

Bench parameters: `TIMEOUT_CYC=1000`, `MIN_HIGH=10`, `MAX_HIGH=20`, 8 ns clock.

1. Reset held 10 cycles → all outputs 0 except `no_signal=1`. First rise → no `valid`.
2. Steady PWM, high 15 cycles / period 100 cycles → from the second rise onward:
   - `valid` each period;
   - `high_count=15`, `period_count=100`, `in_range=1`, `no_signal=0`;
   - `valid` appears 3 edges after each input rise.
3. High time 5, then 25, period 100 → `in_range=0` for both. Switching to high time 10 and then 20 → `in_range=1`, inclusive at both bounds.
4. Input held high for 1200 cycles after a rise → at cycle 1000 the counts clear and `no_signal=1`. Repeat with input held low → same result. Resuming the PWM → the first period is dropped and the second publishes.
5. Reset pulsed mid-period (during HIGH) → outputs return to reset values. The next two rises publish only one measurement, with correct counts.
6. Single-cycle glitch pulses (high 1, low 1) → `high_count=1`, `period_count=2`. Period of exactly 999 → published. Period of 1000 → timeout.
